line_cmd_scheduler: RTL and testbench

- Command scheduler in front of the Bresenham line engine.
- Accepts line requests (x0,y0,x1,y1) from two requesters and arbitrates between them round-robin.
- Buffers accepted requests in a small FIFO. Issues one line at a time to the engine, starting only during vertical blanking.
- Supervises engine completion with a timeout watchdog.

---
 rtl/line_cmd_scheduler.sv | 118 +++++++++++
 tb/tb_line_cmd_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/line_cmd_scheduler.sv
// Line command scheduler: round-robin intake from two requesters into a small FIFO,
// issuing one line at a time to the line engine during vertical blanking, with a completion watchdog.
module line_cmd_scheduler #(
   parameter int XW      = 10,
   parameter int YW      = 10,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [2*XW+2*YW-1:0]      req0_cmd,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [2*XW+2*YW-1:0]      req1_cmd,
   input  logic                      vblank,
   output logic                      eng_start,
   output logic [XW-1:0]             eng_x0,
   output logic [YW-1:0]             eng_y0,
   output logic [XW-1:0]             eng_x1,
   output logic [YW-1:0]             eng_y1,
   input  logic                      eng_done,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      busy,
   output logic                      err_timeout
);

   localparam int CW = 2*XW + 2*YW;
   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

   state_t          state_q, state_d;
   logic            rrPtr_q;
   logic [AW-1:0]   wrPtr_q, rdPtr_q;
   logic [AW:0]     count_q;
   logic [CW-1:0]   mem [DEPTH];
   logic [WW-1:0]   wdog_q;
   logic            err_q;
   logic            errSet;
   logic [CW-1:0]   engCmd_q;
   logic            full, grant0, grant1, push, pop;
   logic [CW-1:0]   pushCmd;

   // Readys are forced low while reset is held so nothing is accepted in a reset cycle.
   always_comb begin
      full    = (count_q == (AW+1)'(DEPTH));
      grant0  = !rst && !full && req0_valid && (!req1_valid || !rrPtr_q);
      grant1  = !rst && !full && req1_valid && (!req0_valid || rrPtr_q);
      push    = grant0 || grant1;
      pushCmd = grant0 ? req0_cmd : req1_cmd;
      pop     = (state_q == IDLE) && (count_q != '0) && vblank;
   end

   always_comb begin
      state_d = state_q;
      errSet  = 1'b0;
      case (state_q)
         IDLE:      if (pop) state_d = ISSUE;
         ISSUE:     state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (eng_done) begin
               state_d = IDLE;
            end else if (wdog_q == WW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               errSet  = 1'b1;
            end
         end
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr_q] <= pushCmd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rrPtr_q  <= 1'b0;
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         wdog_q   <= '0;
         err_q    <= 1'b0;
         engCmd_q <= '0;
      end else begin
         state_q <= state_d;
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
            rrPtr_q <= grant0;
         end
         if (pop) begin
            engCmd_q <= mem[rdPtr_q];
            rdPtr_q  <= rdPtr_q + 1'b1;
         end
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         // The watchdog restarts from zero on every entry into WAIT_DONE.
         wdog_q <= (state_q == WAIT_DONE) ? wdog_q + 1'b1 : '0;
         if (errSet) err_q <= 1'b1;
      end
   end

   assign req0_ready  = grant0;
   assign req1_ready  = grant1;
   assign eng_start   = (state_q == ISSUE) && !rst;
   assign busy        = (state_q != IDLE);
   assign fifo_count  = count_q;
   assign err_timeout = err_q;
   assign eng_x0      = engCmd_q[2*YW+XW +: XW];
   assign eng_y0      = engCmd_q[YW+XW +: YW];
   assign eng_x1      = engCmd_q[YW +: XW];
   assign eng_y1      = engCmd_q[0 +: YW];

endmodule

// File: tb/tb_line_cmd_scheduler.sv
// Randomized scoreboard bench for line_cmd_scheduler with a transaction-level reference model.
module tb_line_cmd_scheduler;

   localparam int XW      = 10;
   localparam int YW      = 10;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int CW      = 2*XW + 2*YW;
   localparam int CNTW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            req0_valid, req1_valid;
   logic            req0_ready, req1_ready;
   logic [CW-1:0]   req0_cmd, req1_cmd;
   logic            vblank;
   logic            eng_start;
   logic [XW-1:0]   eng_x0, eng_x1;
   logic [YW-1:0]   eng_y0, eng_y1;
   logic            eng_done;
   logic [CNTW-1:0] fifo_count;
   logic            busy;
   logic            err_timeout;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [CW-1:0] modelQ[$];
   logic [CW-1:0] expQ[$];
   int            favour;
   int            lineAge;
   logic          expErr;
   logic [CW-1:0] lastCmd;
   logic          vbState;

   always #5 clk = ~clk;

   line_cmd_scheduler #(.XW(XW), .YW(YW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
      .vblank(vblank), .eng_start(eng_start),
      .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
      .eng_done(eng_done), .fifo_count(fifo_count), .busy(busy), .err_timeout(err_timeout)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] randCmd();
      return CW'({$urandom(), $urandom()});
   endfunction

   // Expected grant: not full, and either the only valid requester or the favoured one.
   function automatic logic expGrant(input int who);
      logic mine, other;
      mine  = (who == 0) ? req0_valid : req1_valid;
      other = (who == 0) ? req1_valid : req0_valid;
      return !rst && mine && (modelQ.size() < DEPTH) && (!other || favour == who);
   endfunction

   // Compares every DUT output against the model for the current cycle.
   task automatic checkOutput();
      check("req0_ready", req0_ready, expGrant(0));
      check("req1_ready", req1_ready, expGrant(1));
      check("eng_start", eng_start, (lineAge == 0) && !rst);
      check("busy", busy, lineAge >= 0);
      check("fifo_count", fifo_count, modelQ.size());
      check("err_timeout", err_timeout, expErr);
      check("eng_cmd_hold", {eng_x0, eng_y0, eng_x1, eng_y1}, lastCmd);
   endtask

   // Advances the reference model by one clock edge using the inputs presented this cycle.
   task automatic updateModel();
      logic g0, g1, popNow;
      logic [CW-1:0] c;
      if (rst) begin
         modelQ.delete();
         expQ.delete();
         favour  = 0;
         lineAge = -1;
         expErr  = 1'b0;
         lastCmd = '0;
         return;
      end
      g0     = expGrant(0);
      g1     = expGrant(1);
      popNow = (lineAge == -1) && (modelQ.size() > 0) && vblank;
      if (lineAge == 0) begin
         lineAge = 1;
      end else if (lineAge >= 1) begin
         if (eng_done) lineAge = -1;
         else if (lineAge == TIMEOUT) begin
            lineAge = -1;
            expErr  = 1'b1;
         end else lineAge++;
      end
      if (popNow) begin
         c = modelQ.pop_front();
         expQ.push_back(c);
         lastCmd = c;
         lineAge = 0;
      end
      if (g0) begin
         modelQ.push_back(req0_cmd);
         favour = 1;
      end else if (g1) begin
         modelQ.push_back(req1_cmd);
         favour = 0;
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [CW-1:0] c0, input logic v1,
                                input logic [CW-1:0] c1, input logic vb, input logic done,
                                input logic r);
      req0_valid = v0;
      req0_cmd   = c0;
      req1_valid = v1;
      req1_cmd   = c1;
      vblank     = vb;
      eng_done   = done;
      rst        = r;
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      updateModel();
      #1;
   endtask

   task automatic runRandom(input int n, input int vPct, input int donePct,
                            input int vbFlipPct, input int rstPermille);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < vbFlipPct) vbState = ~vbState;
         applyStimulus($urandom_range(99) < vPct, randCmd(), $urandom_range(99) < vPct, randCmd(),
                       vbState, $urandom_range(99) < donePct, $urandom_range(999) < rstPermille);
      end
   endtask

   // Scoreboard monitor: each start pulse must carry the oldest predicted command.
   initial begin
      logic [CW-1:0] e;
      forever begin
         @(negedge clk);
         if (eng_start === 1'b1) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected_start: got %0h, expected no start at %0t",
                        {eng_x0, eng_y0, eng_x1, eng_y1}, $time);
            end else begin
               e = expQ.pop_front();
               check("issued_cmd", {eng_x0, eng_y0, eng_x1, eng_y1}, e);
            end
         end
      end
   end

   initial begin
      logic [CW-1:0] single;
      vbState = 1'b0;
      favour  = 0;
      lineAge = -1;
      expErr  = 1'b0;
      lastCmd = '0;
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      req0_cmd = '0; req1_cmd = '0; vblank = 1'b0; eng_done = 1'b0;
      @(posedge clk);
      updateModel();
      #1;
      for (int i = 0; i < 5; i++) applyStimulus(1, randCmd(), 1, randCmd(), 1, 0, 1);

      single = {10'd10, 10'd20, 10'd300, 10'd200};
      applyStimulus(1, single, 0, '0, 1, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, '0, 1, 0, 0);
      applyStimulus(0, '0, 0, '0, 1, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, '0, 1, 0, 0);

      for (int i = 0; i < 8; i++) applyStimulus(1, randCmd(), 1, randCmd(), 0, 0, 0);
      for (int i = 0; i < 50; i++) applyStimulus(0, '0, 0, '0, 0, 0, 0);
      applyStimulus(0, '0, 0, '0, 1, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, '0, 0, '0, 0, 0, 0);
      applyStimulus(0, '0, 0, '0, 0, 1, 0);
      for (int i = 0; i < 20; i++) applyStimulus(0, '0, 0, '0, 0, 0, 0);

      for (int i = 0; i < 45; i++) applyStimulus(0, '0, 0, '0, 1, 0, 0);
      vbState = 1'b1;
      runRandom(100, 40, 30, 5, 0);
      applyStimulus(1, randCmd(), 1, randCmd(), 1, 0, 1);
      applyStimulus(1, randCmd(), 1, randCmd(), 1, 0, 1);

      runRandom(2500, 50, 30, 6, 4);
      runRandom(300, 80, 0, 2, 0);
      runRandom(300, 30, 50, 10, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
